// File: rtl/counter_poke_peek_ctrl_if.sv
// Command/response channel between a test sequencer (master) and the
// counter poke/peek controller (slave).
interface counter_poke_peek_ctrl_if #(
    parameter int WIDTH = 32
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [1:0]       rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_status
    );
endinterface

// File: rtl/counter_poke_peek_ctrl.sv
// Host-side poke/peek controller for a free-running counter target.
// READ samples the count, WRITE backdoor-loads the target and verifies the
// reloaded count, WAIT_UNTIL polls until the count reaches a target value
// (wrap-safe) or a cycle budget runs out. One response per command.
module counter_poke_peek_ctrl #(
    parameter int WIDTH          = 32,
    parameter int VERIFY_SLACK   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    counter_poke_peek_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]         count_in,
    output logic                     update_out,
    output logic [WIDTH-1:0]         value_out
);
    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_WAIT  = 2'd2;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_MISMATCH = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_BAD_OP   = 2'd3;

    // +1 keeps the counter at least one bit wide when TIMEOUT_CYCLES == 1
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0] SLACK    = WIDTH'(VERIFY_SLACK);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_VERIFY,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] data_r, data_s;
    logic [WIDTH-1:0] value_r, value_s;
    logic             update_r, update_s;
    logic             rsp_valid_r, rsp_valid_s;
    logic [WIDTH-1:0] rsp_data_r, rsp_data_s;
    logic [1:0]       rsp_status_r, rsp_status_s;
    logic [CNT_W-1:0] wait_cnt_r, wait_cnt_s;
    logic             ready_r, ready_s;
    logic [WIDTH-1:0] diff_s;

    // Modulo-2^WIDTH distance of the live count past the latched value;
    // MSB clear means the count is at or past it (wrap-safe).
    assign diff_s = count_in - data_r;

    assign bus.cmd_ready  = ready_r & ~reset;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_status = rsp_status_r;
    assign update_out     = update_r;
    assign value_out      = value_r;

    // Next-state and next-output decode; everything holds unless a branch changes it.
    always_comb begin
        state_s      = state_r;
        data_s       = data_r;
        value_s      = value_r;
        update_s     = 1'b0;
        rsp_valid_s  = rsp_valid_r;
        rsp_data_s   = rsp_data_r;
        rsp_status_s = rsp_status_r;
        wait_cnt_s   = wait_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    data_s = bus.cmd_data;
                    case (bus.cmd_op)
                        OP_READ: begin
                            state_s      = S_RESP;
                            rsp_valid_s  = 1'b1;
                            rsp_data_s   = count_in;
                            rsp_status_s = ST_OK;
                        end
                        OP_WRITE: begin
                            state_s  = S_WRITE;
                            value_s  = bus.cmd_data;
                            update_s = 1'b1;
                        end
                        OP_WAIT: begin
                            state_s    = S_WAIT;
                            wait_cnt_s = {CNT_W{1'b0}};
                        end
                        default: begin
                            state_s      = S_RESP;
                            rsp_valid_s  = 1'b1;
                            rsp_data_s   = {WIDTH{1'b0}};
                            rsp_status_s = ST_BAD_OP;
                        end
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WRITE: begin
                // the load strobe was the single cycle spent here
                state_s = S_VERIFY;
            end
            S_VERIFY: begin
                state_s      = S_RESP;
                rsp_valid_s  = 1'b1;
                rsp_data_s   = count_in;
                rsp_status_s = (diff_s <= SLACK) ? ST_OK : ST_MISMATCH;
            end
            S_WAIT: begin
                if (!diff_s[WIDTH-1]) begin
                    state_s      = S_RESP;
                    rsp_valid_s  = 1'b1;
                    rsp_data_s   = count_in;
                    rsp_status_s = ST_OK;
                end else if (wait_cnt_r == CNT_LAST) begin
                    state_s      = S_RESP;
                    rsp_valid_s  = 1'b1;
                    rsp_data_s   = count_in;
                    rsp_status_s = ST_TIMEOUT;
                end else begin
                    wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_s     = S_IDLE;
                    rsp_valid_s = 1'b0;
                end else begin
                    state_s = S_RESP;
                end
            end
            default: begin
                state_s     = S_IDLE;
                rsp_valid_s = 1'b0;
            end
        endcase
        ready_s = (state_s == S_IDLE);
    end

    // State and registered outputs; reset drops any in-flight command silently.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= S_IDLE;
            data_r       <= {WIDTH{1'b0}};
            value_r      <= {WIDTH{1'b0}};
            update_r     <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {WIDTH{1'b0}};
            rsp_status_r <= ST_OK;
            wait_cnt_r   <= {CNT_W{1'b0}};
            ready_r      <= 1'b1;
        end else begin
            state_r      <= state_s;
            data_r       <= data_s;
            value_r      <= value_s;
            update_r     <= update_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_data_r   <= rsp_data_s;
            rsp_status_r <= rsp_status_s;
            wait_cnt_r   <= wait_cnt_s;
            ready_r      <= ready_s;
        end
    end
endmodule

// File: tb/tb_counter_poke_peek_ctrl.sv
// Self-checking bench for counter_poke_peek_ctrl: directed and random
// commands with a count_in ramp per command, checked against a reference
// model that computes response, status and latency from the command rules.
module tb_counter_poke_peek_ctrl;
    localparam int WIDTH = 32;
    localparam int SLACK = 2;
    localparam int TMO   = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] count_in;
    logic        update_out;
    logic [31:0] value_out;

    int total = 0;
    int bad   = 0;

    counter_poke_peek_ctrl_if #(.WIDTH(WIDTH)) bus ();

    counter_poke_peek_ctrl #(
        .WIDTH         (WIDTH),
        .VERIFY_SLACK  (SLACK),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .count_in  (count_in),
        .update_out(update_out),
        .value_out (value_out)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one command. count_in is base at the accept edge and base+k*step
    // at the k-th edge after it; hold = cycles of rsp_ready backpressure.
    task automatic run_cmd(input logic [1:0] op, input logic [31:0] data,
                           input logic [31:0] base, input logic [31:0] step, input int hold);
        int          lat;
        logic [31:0] edata, c, d;
        logic [1:0]  estat;
        logic        reached;
        // reference model
        case (op)
            2'd0: begin lat = 1; edata = base; estat = 2'd0; end
            2'd1: begin
                lat   = 3;
                c     = base + 2 * step;
                d     = c - data;
                edata = c;
                estat = (d <= 32'(SLACK)) ? 2'd0 : 2'd1;
            end
            2'd2: begin
                lat     = TMO + 1;
                estat   = 2'd2;
                edata   = base + TMO * step;
                reached = 1'b0;
                for (int kk = 1; kk <= TMO; kk++) begin
                    if (!reached) begin
                        c = base + kk * step;
                        d = c - data;
                        if (d < 32'h8000_0000) begin
                            reached = 1'b1;
                            lat     = kk + 1;
                            edata   = c;
                            estat   = 2'd0;
                        end
                    end
                end
            end
            default: begin lat = 1; edata = 32'd0; estat = 2'd3; end
        endcase

        check_val("idle_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        count_in      = base;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_data  = $urandom;
        for (int k = 0; k < lat; k++) begin
            check_val("update", 32'(update_out), 32'(op == 2'd1 && k == 0));
            if (op == 2'd1 && k == 0) check_val("value", value_out, data);
            check_val("busy_ready", 32'(bus.cmd_ready), 32'd0);
            check_val("rsp_valid", 32'(bus.rsp_valid), 32'(k + 1 == lat));
            if (k + 1 < lat) begin
                count_in = base + (k + 1) * step;
                tick();
            end
        end
        check_val("rsp_data", bus.rsp_data, edata);
        check_val("rsp_status", 32'(bus.rsp_status), 32'(estat));
        for (int h = 0; h < hold; h++) begin
            count_in      = $urandom;
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 2'($urandom);
            tick();
            check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
            check_val("hold_data", bus.rsp_data, edata);
            check_val("hold_status", 32'(bus.rsp_status), 32'(estat));
            check_val("hold_ready", 32'(bus.cmd_ready), 32'd0);
            check_val("hold_update", 32'(update_out), 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check_val("done_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("done_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("done_update", 32'(update_out), 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] data, base, step;

        reset         = 1'b1;
        count_in      = 32'd0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_data  = 32'd0;
        bus.rsp_ready = 1'b0;
        tick();
        tick();
        check_val("rst_ready_low", 32'(bus.cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_val("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check_val("rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("rst_data", bus.rsp_data, 32'd0);
        check_val("rst_status", 32'(bus.rsp_status), 32'd0);
        check_val("rst_update", 32'(update_out), 32'd0);
        check_val("rst_value", value_out, 32'd0);
        tick();

        // directed cases
        run_cmd(2'd0, 32'h1234_5678, 32'h0000_0010, 32'd0, 5);
        run_cmd(2'd1, 32'h0000_ABCD, 32'h0000_ABCE, 32'd0, 0);
        run_cmd(2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1);
        run_cmd(2'd1, 32'hFFFF_FFFF, 32'h0000_0005, 32'd0, 0);
        run_cmd(2'd1, 32'h0000_1000, 32'h0000_1003, 32'd0, 0);
        run_cmd(2'd2, 32'd105, 32'd100, 32'd1, 2);
        run_cmd(2'd2, 32'd60, 32'd50, 32'd0, 0);
        run_cmd(2'd2, 32'h0000_0002, 32'hFFFF_FFFE, 32'd1, 0);
        run_cmd(2'd2, 32'd7, 32'd7, 32'd0, 0);
        run_cmd(2'd3, 32'hDEAD_BEEF, 32'h0000_0042, 32'd1, 3);

        // reset in the cycle WAIT is entered
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_data  = 32'd60;
        count_in      = 32'd50;
        tick();
        bus.cmd_valid = 1'b0;
        reset         = 1'b1;
        #1;
        check_val("mid_rst_ready_low", 32'(bus.cmd_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check_val("mid_rst_update", 32'(update_out), 32'd0);
        check_val("mid_rst_ready", 32'(bus.cmd_ready), 32'd1);
        run_cmd(2'd0, 32'd0, 32'h0000_0077, 32'd1, 0);

        // reset while the load strobe is high
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        bus.cmd_data  = 32'h5555_AAAA;
        tick();
        bus.cmd_valid = 1'b0;
        check_val("wr_strobe", 32'(update_out), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check_val("wr_rst_update", 32'(update_out), 32'd0);
        check_val("wr_rst_value", value_out, 32'd0);
        check_val("wr_rst_ready", 32'(bus.cmd_ready), 32'd1);
        tick();

        // random commands
        for (int n = 0; n < 60; n++) begin
            op   = 2'($urandom_range(0, 3));
            data = $urandom;
            step = 32'($urandom_range(0, 2));
            case (op)
                2'd1:    base = data + 32'($urandom_range(0, 5)) - 2 * step;
                2'd2:    base = data - 32'($urandom_range(0, 12));
                default: base = $urandom;
            endcase
            run_cmd(op, data, base, step, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
